// File: rtl/calc_pkg.sv
// Shared definitions for the keypad calculator execution sequencer:
// state encoding, datapath widths, operator bit positions and small helpers.
package calc_pkg;

  localparam int MUL_STEPS  = 7;   // one step per bit of the 7-bit operand B
  localparam int BIN_W      = 14;  // binary result width (99*99 = 9801)
  localparam int BCD_DIGITS = 4;
  localparam int DIGIT_MAX  = 9;
  localparam int OPND_W     = 7;   // 2-digit operand in binary (0..99)
  localparam int BCD_W      = 4 * BCD_DIGITS;

  // Bit positions of the one-hot operator vector {op_mul, op_sub, op_add}
  localparam int OP_ADD_BIT = 0;
  localparam int OP_SUB_BIT = 1;
  localparam int OP_MUL_BIT = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ALU,
    ST_MUL,
    ST_CONV,
    ST_DONE
  } state_e;

  // Request captured in the cycle start is accepted
  typedef struct packed {
    logic [3:0] a_tens;
    logic [3:0] a_ones;
    logic [3:0] b_tens;
    logic [3:0] b_ones;
    logic [2:0] op;
  } req_t;

  function automatic logic digit_ok(input logic [3:0] d);
    return d <= 4'(DIGIT_MAX);
  endfunction

  function automatic logic is_one_hot3(input logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

  // Two BCD digits to binary; only meaningful for legal digits
  function automatic logic [OPND_W-1:0] bcd2_to_bin(input logic [3:0] tens,
                                                    input logic [3:0] ones);
    return OPND_W'(tens) * OPND_W'(10) + OPND_W'(ones);
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: 14-bit binary to 4 BCD digits.
// A start pulse loads the operand; the following 14 cycles each perform one
// adjust-and-shift step. done_o is high during the last step and bcd_o then
// carries the finished result (the value being written this cycle).
module bin2bcd_seq
  import calc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             start_i,
  input  logic [BIN_W-1:0] bin_i,
  output logic             done_o,
  output logic [BCD_W-1:0] bcd_o
);

  logic [BIN_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [BCD_W-1:0] adj;

  // One double-dabble step per cycle while steps remain
  always_comb begin
    // NOTE: every signal written here gets a default first so no path can
    // leave it unassigned and infer a latch.
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    done_o = 1'b0;
    adj    = bcd_q;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end

    if (clr_i) begin
      bin_d = '0;
      bcd_d = '0;
      cnt_d = '0;
    end else if (start_i) begin
      bin_d = bin_i;
      bcd_d = '0;
      cnt_d = 4'(BIN_W);
    end else if (cnt_q != 4'd0) begin
      {bcd_d, bin_d} = {adj[BCD_W-2:0], bin_q, 1'b0};
      cnt_d          = cnt_q - 4'd1;
      done_o         = (cnt_q == 4'd1);
    end
  end

  assign bcd_o = bcd_d;

  // Converter state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops
      // update together from pre-edge values.
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/calc_exec_ctrl.sv
// Execution sequencer for the two-operand keypad calculator. Accepts two
// 2-digit BCD operands and a one-hot operator, runs add/sub (1 cycle) or a
// 7-step shift-add multiply, converts the result to BCD and holds it.
module calc_exec_ctrl
  import calc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clear,
  input  logic             op_add,
  input  logic             op_sub,
  input  logic             op_mul,
  input  logic [3:0]       a_tens,
  input  logic [3:0]       a_ones,
  input  logic [3:0]       b_tens,
  input  logic [3:0]       b_ones,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             neg,
  output logic [BCD_W-1:0] res_bcd
);

  state_e            state_q, state_d;
  req_t              req_q, req_d;
  logic [OPND_W-1:0] a_q, a_d, b_q, b_d;
  logic [BIN_W-1:0]  acc_q, acc_d, partial;
  logic [2:0]        step_q, step_d;
  logic              sign_q, sign_d;
  logic              err_q, err_d;
  logic              neg_q, neg_d;
  logic [BCD_W-1:0]  res_q, res_d;

  logic              req_legal;
  logic              conv_start;
  logic [BIN_W-1:0]  conv_bin;
  logic              conv_done;
  logic [BCD_W-1:0]  conv_bcd;

  assign req_legal = digit_ok(req_q.a_tens) && digit_ok(req_q.a_ones) &&
                     digit_ok(req_q.b_tens) && digit_ok(req_q.b_ones) &&
                     is_one_hot3(req_q.op);

  // Next-state, datapath and converter handshake for the sequencer
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    step_d     = step_q;
    sign_d     = sign_q;
    err_d      = err_q;
    neg_d      = neg_q;
    res_d      = res_q;
    partial    = '0;
    conv_start = 1'b0;
    conv_bin   = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          req_d   = '{a_tens: a_tens, a_ones: a_ones, b_tens: b_tens,
                      b_ones: b_ones, op: {op_mul, op_sub, op_add}};
          err_d   = 1'b0;
          neg_d   = 1'b0;
          res_d   = '0;
          sign_d  = 1'b0;
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        if (req_legal) begin
          a_d     = bcd2_to_bin(req_q.a_tens, req_q.a_ones);
          b_d     = bcd2_to_bin(req_q.b_tens, req_q.b_ones);
          acc_d   = '0;
          step_d  = '0;
          state_d = req_q.op[OP_MUL_BIT] ? ST_MUL : ST_ALU;
        end else begin
          err_d   = 1'b1;
          neg_d   = 1'b0;
          res_d   = '0;
          state_d = ST_DONE;
        end
      end

      ST_ALU: begin
        if (req_q.op[OP_ADD_BIT]) begin
          conv_bin = BIN_W'(a_q) + BIN_W'(b_q);
          sign_d   = 1'b0;
        end else if (a_q >= b_q) begin
          // A == B lands here, so a zero difference is never negative
          conv_bin = BIN_W'(a_q - b_q);
          sign_d   = 1'b0;
        end else begin
          conv_bin = BIN_W'(b_q - a_q);
          sign_d   = 1'b1;
        end
        conv_start = 1'b1;
        state_d    = ST_CONV;
      end

      ST_MUL: begin
        if (b_q[step_q]) begin
          partial = BIN_W'(a_q) << step_q;
        end
        acc_d  = acc_q + partial;
        step_d = step_q + 3'd1;
        if (step_q == 3'(MUL_STEPS - 1)) begin
          // Final partial product goes straight into the converter
          conv_start = 1'b1;
          conv_bin   = acc_d;
          sign_d     = 1'b0;
          state_d    = ST_CONV;
        end
      end

      ST_CONV: begin
        if (conv_done) begin
          res_d   = conv_bcd;
          neg_d   = sign_q;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Synchronous abort beats everything, including a same-cycle start
    if (clear) begin
      state_d = ST_IDLE;
      req_d   = '0;
      a_d     = '0;
      b_d     = '0;
      acc_d   = '0;
      step_d  = '0;
      sign_d  = 1'b0;
      err_d   = 1'b0;
      neg_d   = 1'b0;
      res_d   = '0;
    end
  end

  // Sequencer and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: datapath registers are reset along with the FSM so an aborted
      // operation leaves no stale operands or partial products behind.
      state_q <= ST_IDLE;
      req_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      step_q  <= '0;
      sign_q  <= 1'b0;
      err_q   <= 1'b0;
      neg_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      step_q  <= step_d;
      sign_q  <= sign_d;
      err_q   <= err_d;
      neg_q   <= neg_d;
      res_q   <= res_d;
    end
  end

  bin2bcd_seq u_bin2bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (clear),
    .start_i (conv_start),
    .bin_i   (conv_bin),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd)
  );

  assign busy    = (state_q == ST_LOAD) || (state_q == ST_ALU) ||
                   (state_q == ST_MUL)  || (state_q == ST_CONV);
  assign done    = (state_q == ST_DONE);
  assign err     = err_q;
  assign neg     = neg_q;
  assign res_bcd = res_q;

endmodule
